// File: rtl/axi_rd_sched.sv
// ============================================================================
// Module   : axi_rd_sched
// Purpose  : Round-robin read scheduler for three requesters onto one AXI
//            read port.
//            Issues one transaction at a time, routes R beats to their owner
//            and holds off reads that hit a line with an in-flight store.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_rd_sched #(
    parameter int LINE_BEATS = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [2:0]  rd_req,
    input  logic [2:0]  rd_line,
    input  logic [5:0]  rd_size,
    input  logic [95:0] rd_addr,
    output logic [2:0]  rd_rdy,
    output logic [2:0]  ret_valid,
    output logic [2:0]  ret_last,
    output logic [31:0] ret_data,
    output logic        ret_err,
    input  logic        wr_pend,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        proto_err
);

    localparam logic [7:0] c_line_len = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_last_grant;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;
    logic [4:0]  r_beat_cnt;
    logic        r_proto_err;

    logic [31:0] w_addr [3];
    logic [1:0]  w_size [3];
    logic [2:0]  w_hazard;
    logic [2:0]  w_elig;
    logic        w_grant_vld;
    logic [1:0]  w_grant_idx;
    logic        w_grant;
    logic        w_beat;
    logic        w_unused;

    // rid is deliberately ignored: the latched arid decides the destination.
    assign w_unused = ^{rid, wr_addr[3:0]};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_req
            assign w_addr[g]   = rd_addr[32*g +: 32];
            assign w_size[g]   = rd_size[2*g +: 2];
            assign w_hazard[g] = wr_pend & (rd_addr[32*g+4 +: 28] == wr_addr[31:4]);
        end
    endgenerate

    assign w_elig = rd_req & ~w_hazard;

    // Scan from last_grant+3 down to last_grant+1 so the nearest successor wins.
    always_comb begin
        logic [1:0] v_try;
        v_try       = 2'd0;
        w_grant_vld = 1'b0;
        w_grant_idx = r_last_grant;
        for (int k = 3; k >= 1; k--) begin
            v_try = 2'((32'(r_last_grant) + 32'(k)) % 32'd3);
            if (w_elig[v_try]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = v_try;
            end
        end
    end

    assign w_grant = aresetn && (r_state == S_IDLE) && w_grant_vld;
    assign w_beat  = aresetn && (r_state == S_DATA) && rvalid;

    always_comb begin
        w_state_nxt = r_state;
        rd_rdy      = 3'b000;
        arvalid     = 1'b0;
        rready      = 1'b0;
        ret_valid   = 3'b000;
        ret_last    = 3'b000;
        ret_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    rd_rdy      = 3'(3'b001 << w_grant_idx);
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                rready = 1'b1;
                if (w_beat) begin
                    ret_valid = 3'(3'b001 << r_arid[1:0]);
                    ret_err   = (rresp != 2'b00);
                    if (rlast) begin
                        ret_last    = 3'(3'b001 << r_arid[1:0]);
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'd2;
            r_arid       <= 4'd0;
            r_araddr     <= 32'd0;
            r_arlen      <= 8'd0;
            r_arsize     <= 3'd0;
            r_beat_cnt   <= 5'd0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_grant_idx;
                r_arid       <= {2'b00, w_grant_idx};
                r_beat_cnt   <= 5'd0;
                if (rd_line[w_grant_idx]) begin
                    r_araddr <= w_addr[w_grant_idx] & ~32'hF;
                    r_arlen  <= c_line_len;
                    r_arsize <= 3'b010;
                end else begin
                    r_araddr <= w_addr[w_grant_idx];
                    r_arlen  <= 8'd0;
                    r_arsize <= {1'b0, w_size[w_grant_idx]};
                end
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 5'd1;
            end
            // Early rlast, or the final expected beat arriving without rlast.
            if (w_beat && (rlast != ({3'b000, r_beat_cnt} == r_arlen))) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign arid      = r_arid;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = r_arsize;
    assign arburst   = 2'b01;
    assign ret_data  = rdata;
    assign proto_err = r_proto_err;

endmodule

`default_nettype wire

// File: doc/axi_rd_sched.md
# axi_rd_sched

Read-side scheduler in front of the AXI master port: arbitrates read requests from the I-cache (requester 0), D-cache refill (requester 1) and uncached load path (requester 2). It issues one AXI read transaction at a time and routes returning beats back to the owning requester. Requests that hit a line with an in-flight store are held off until the write drains.

## Interface
Parameters:
- LINE_BEATS, 4, beats per cache-line burst; arlen = LINE_BEATS-1 for line reads. Legal range 2..16.

Ports (aclk rising edge; reset aresetn synchronous, active-low):
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- rd_req  in  3  per-requester read request, held until rd_rdy
- rd_line  in  3  per-requester: 1 = line burst, 0 = single beat
- rd_size  in  6  2 bits per requester, {req2,req1,req0}; log2 bytes for single-beat reads
- rd_addr  in  96  32 bits per requester, {req2,req1,req0}
- rd_rdy  out  3  one-hot accept pulse for the granted requester
- ret_valid  out  3  one-hot beat-valid to the owning requester
- ret_last  out  3  one-hot, with final beat
- ret_data  out  32  returned beat, shared by all requesters
- ret_err  out  1  pulses with a beat whose rresp != 0
- wr_pend  in  1  a store is accepted but its bvalid has not yet arrived
- wr_addr  in  32  address of that store
- arid  out  4  {2'b0, grant index}
- araddr  out  32  read address
- arlen  out  8  burst length minus 1
- arsize  out  3  beat size
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  R id
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- proto_err  out  1  sticky; beat count disagreed with rlast

## Operation
- FSM states: IDLE, ADDR, DATA. Only one transaction is outstanding at a time.
- IDLE:
  - Eligible set = rd_req & ~hazard, where hazard[i] = wr_pend & (rd_addr_i[31:4] == wr_addr[31:4]).
  - Arbitration is round-robin, starting from the index after last_grant.
  - If the eligible set is non-empty: pulse rd_rdy[g]; latch arid/araddr/arlen/arsize; last_grant <= g; go to ADDR.
- Latched fields on grant:
  - Line read (rd_line[g]=1): araddr = rd_addr_g & ~32'hF, arlen = LINE_BEATS-1, arsize = 3'b010.
  - Single read: araddr = rd_addr_g, arlen = 0, arsize = {1'b0, rd_size_g}.
- ADDR: arvalid = 1 until arvalid & arready, then go to DATA. Address fields stay stable while arvalid is high.
- DATA: rready = 1.
  - On each rvalid & rready: ret_valid[arid[1:0]] = 1 and ret_data = rdata, combinationally the same cycle. ret_err = (rresp != 0).
  - On rlast: ret_last[arid[1:0]] = 1 and next state is IDLE.
- Beat counter (5 bits):
  - Clears on grant and increments per beat.
  - Set proto_err (sticky until reset) if rlast arrives with count != arlen, or if count reaches arlen without rlast.
  - rlast always governs completion; extra beats are still forwarded.
- rid is not checked for routing; arid selects the destination.

## Timing
- Reset values:
  - state = IDLE, last_grant = 2 (requester 0 wins first).
  - arvalid = rready = 0; rd_rdy = ret_valid = ret_last = 0; ret_err = proto_err = 0.
  - arid/araddr/arlen/arsize = 0; arburst = 2'b01.
- Grant to arvalid: grant in cycle T (rd_rdy pulse); arvalid is high from T+1.
- Returned beats reach the requester with zero added latency.
- After the rlast beat in cycle T, the FSM is in IDLE at T+1 and the next grant can happen at T+1. Minimum issue interval for single reads with arready and rvalid immediate: 3 cycles.
- A hazard is evaluated every IDLE cycle. A blocked requester keeps rd_req high and is granted in the first cycle wr_pend drops or the address no longer matches.
- rd_req deasserting while ungranted is legal. rd_req must not change address while asserted.
- Reset mid-transaction: return to IDLE next cycle and drop all outputs. Outstanding AXI beats are the interconnect's reset responsibility.
- Simultaneous arvalid&arready and rvalid cannot occur, because rready is low in ADDR.

## Test plan
- Single read: requester 2 read, addr 0x1C000104, size 2, arready at T+1, rvalid+rlast with rdata 0xDEADBEEF two cycles later -> arid 2, arlen 0, arsize 2; ret_valid=3'b100, ret_last=3'b100, ret_data 0xDEADBEEF.
- Line read: requester 0 line read at 0x1C000008 -> araddr 0x1C000000, arlen 3; 4 beats give ret_valid[0] ×4 and ret_last[0] only on beat 4; proto_err stays 0.
- Round-robin: all three rd_req held high across 6 transactions -> grant order 0,1,2,0,1,2.
- Hazard: wr_pend=1, wr_addr 0x00001004, requester 1 line read 0x0000100C, requester 2 read 0x2000 -> requester 2 granted first. Requester 1 is granted the cycle after wr_pend falls.
- Errors: rresp=2'b10 on beat 2 -> ret_err pulses that cycle. rlast on beat 3 of a 4-beat line -> proto_err=1 and FSM returns to IDLE.
- Reset in DATA after 2 beats -> next cycle all outputs at reset values and a fresh request is granted normally.
